// File: rtl/rns_mul_seq.sv
// RNS residue multiply sequencer: one shared modular multiplier, time-shared
// over three channels, with valid/ready handshakes on operands and results.
module rns_mul_seq #(
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RW-1:0] in_a1,
    input  logic [RW-1:0] in_a2,
    input  logic [RW-1:0] in_a3,
    input  logic [RW-1:0] in_b1,
    input  logic [RW-1:0] in_b2,
    input  logic [RW-1:0] in_b3,
    input  logic [RW-1:0] in_m1,
    input  logic [RW-1:0] in_m2,
    input  logic [RW-1:0] in_m3,
    output logic [RW-1:0] mul_res1,
    output logic [RW-1:0] mul_res2,
    output logic [RW-1:0] mul_moduli,
    input  logic [RW-1:0] mul_out,
    output logic [1:0]    mul_sel,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_p1,
    output logic [RW-1:0] out_p2,
    output logic [RW-1:0] out_p3,
    output logic          out_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CH1,
        S_CH2,
        S_CH3,
        S_DONE
    } state_t;

    localparam logic [RW-1:0] M_MIN = RW'(2);

    state_t                 state_q, state_d;
    logic [2:0][RW-1:0]     a_q, a_d;
    logic [2:0][RW-1:0]     b_q, b_d;
    logic [2:0][RW-1:0]     m_q, m_d;
    logic [2:0][RW-1:0]     p_q, p_d;
    logic                   err_q, err_d;
    logic                   illegal;

    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (m_q[i] < M_MIN || a_q[i] >= m_q[i] || b_q[i] >= m_q[i])
                illegal = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        p_d     = p_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = {in_a3, in_a2, in_a1};
                    b_d     = {in_b3, in_b2, in_b1};
                    m_d     = {in_m3, in_m2, in_m1};
                    state_d = S_CH1;
                end
            end
            S_CH1: begin
                p_d[0]  = mul_out;
                state_d = S_CH2;
            end
            S_CH2: begin
                p_d[1]  = mul_out;
                state_d = S_CH3;
            end
            S_CH3: begin
                // Flag is captured together with the last product.
                p_d[2]  = mul_out;
                err_d   = illegal;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_sel    = 2'd0;
        mul_res1   = '0;
        mul_res2   = '0;
        mul_moduli = '0;
        unique case (state_q)
            S_CH1: begin
                mul_sel    = 2'd1;
                mul_res1   = a_q[0];
                mul_res2   = b_q[0];
                mul_moduli = m_q[0];
            end
            S_CH2: begin
                mul_sel    = 2'd2;
                mul_res1   = a_q[1];
                mul_res2   = b_q[1];
                mul_moduli = m_q[1];
            end
            S_CH3: begin
                mul_sel    = 2'd3;
                mul_res1   = a_q[2];
                mul_res2   = b_q[2];
                mul_moduli = m_q[2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            p_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            p_q     <= p_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_p1    = p_q[0];
    assign out_p2    = p_q[1];
    assign out_p3    = p_q[2];
    assign out_err   = err_q;

endmodule

// File: tb/tb_rns_mul_seq.sv
// Bench for rns_mul_seq: behavioural shared multiplier plus a per-set
// arithmetic reference model; randomized and directed scenarios.
module tb_rns_mul_seq;

    localparam int RW = 3;
    typedef logic [2:0][RW-1:0] trip_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_a1, in_a2, in_a3;
    logic [RW-1:0] in_b1, in_b2, in_b3;
    logic [RW-1:0] in_m1, in_m2, in_m3;
    logic [RW-1:0] mul_res1, mul_res2, mul_moduli, mul_out;
    logic [1:0]    mul_sel;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_p1, out_p2, out_p3;
    logic          out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rns_mul_seq #(.RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
        .in_b1(in_b1), .in_b2(in_b2), .in_b3(in_b3),
        .in_m1(in_m1), .in_m2(in_m2), .in_m3(in_m3),
        .mul_res1(mul_res1), .mul_res2(mul_res2),
        .mul_moduli(mul_moduli), .mul_out(mul_out),
        .mul_sel(mul_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p1(out_p1), .out_p2(out_p2), .out_p3(out_p3),
        .out_err(out_err)
    );

    // Stand-in for the external combinational residue multiplier.
    function automatic logic [RW-1:0] mul_unit(input logic [RW-1:0] x, y, md);
        if (md == '0) return '0;
        return RW'((int'(x) * int'(y)) % int'(md));
    endfunction
    assign mul_out = mul_unit(mul_res1, mul_res2, mul_moduli);

    function automatic trip_t ref_prod(input trip_t a, b, m);
        trip_t r;
        for (int i = 0; i < 3; i++)
            r[i] = (m[i] == 0) ? '0 : RW'((int'(a[i]) * int'(b[i])) % int'(m[i]));
        return r;
    endfunction

    function automatic logic ref_err(input trip_t a, b, m);
        for (int i = 0; i < 3; i++)
            if (m[i] < 2 || a[i] >= m[i] || b[i] >= m[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic trip_t rnd_trip(input int lo);
        trip_t t;
        for (int i = 0; i < 3; i++)
            t[i] = RW'($urandom_range(lo, (1 << RW) - 1));
        return t;
    endfunction

    function automatic trip_t outp();
        return {out_p3, out_p2, out_p1};
    endfunction

    task automatic drive(input trip_t a, b, m);
        {in_a3, in_a2, in_a1} = a;
        {in_b3, in_b2, in_b1} = b;
        {in_m3, in_m2, in_m1} = m;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one set through; returns results and edges from accept to out_valid.
    task automatic run_op(input trip_t a, b, m, input int stall,
                          input bit scramble, output trip_t p,
                          output logic err, output int lat);
        int n;
        lat = -1;
        p = '0;
        err = 1'b0;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        drive(a, b, m);
        in_valid = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            if (scramble) drive(rnd_trip(0), rnd_trip(0), rnd_trip(0));
            tick();
            n++;
        end
        if (!out_valid) return;
        lat = n;
        repeat (stall) tick();
        p = outp();
        err = out_err;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_sel !== 2'd0 ||
            outp() !== '0 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rdy=%b vld=%b sel=%0d p=%h err=%b want 1 0 0 0 0",
                     in_ready, out_valid, mul_sel, outp(), out_err);
        end
        checks++;
        if ({mul_res1, mul_res2, mul_moduli} !== '0) begin
            errors++;
            $display("FAIL reset_mulin got %h want 0", {mul_res1, mul_res2, mul_moduli});
        end
        checks++;
        rst_n = 1'b1;
        tick();
        drive({3'd2, 3'd4, 3'd3}, {3'd1, 3'd3, 3'd5}, {3'd3, 3'd5, 3'd7});
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        if (mul_sel !== 2'd2) begin
            errors++;
            $display("FAIL reset_reach_ch2 sel=%0d want 2", mul_sel);
        end
        checks++;
        rst_n = 1'b0;
        tick();
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_sel !== 2'd0 ||
            outp() !== '0) begin
            errors++;
            $display("FAIL reset_mid_ch2 rdy=%b vld=%b sel=%0d p=%h want 1 0 0 0",
                     in_ready, out_valid, mul_sel, outp());
        end
        checks++;
        rst_n = 1'b1;
        tick();
        if (in_ready !== 1'b1 || mul_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_no_resume rdy=%b sel=%0d want 1 0", in_ready, mul_sel);
        end
        checks++;
    endtask

    task automatic test_basic();
        trip_t a, b, m;
        logic [1:0] want_sel;
        a = {3'd2, 3'd4, 3'd3};
        b = {3'd1, 3'd3, 3'd5};
        m = {3'd3, 3'd5, 3'd7};
        out_ready = 1'b1;
        drive(a, b, m);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            want_sel = 2'(k);
            if (mul_sel !== want_sel || in_ready !== 1'b0 ||
                mul_res1 !== a[k-1] || mul_res2 !== b[k-1] ||
                mul_moduli !== m[k-1]) begin
                errors++;
                $display("FAIL basic_ch%0d sel=%0d rdy=%b in=%0d,%0d,%0d want %0d 0 %0d,%0d,%0d",
                         k, mul_sel, in_ready, mul_res1, mul_res2, mul_moduli,
                         want_sel, a[k-1], b[k-1], m[k-1]);
            end
            checks++;
            tick();
        end
        if (out_valid !== 1'b1 || outp() !== {3'd2, 3'd2, 3'd1} || out_err !== 1'b0 ||
            mul_sel !== 2'd0) begin
            errors++;
            $display("FAIL basic_result vld=%b p=%h err=%b sel=%0d want 1 %h 0 0",
                     out_valid, outp(), out_err, mul_sel, {3'd2, 3'd2, 3'd1});
        end
        checks++;
        tick();
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        checks++;
    endtask

    task automatic test_backpressure();
        trip_t want;
        bit bad;
        want = {3'd2, 3'd2, 3'd1};
        out_ready = 1'b0;
        drive({3'd2, 3'd4, 3'd3}, {3'd1, 3'd3, 3'd5}, {3'd3, 3'd5, 3'd7});
        in_valid = 1'b1;
        tick();
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b1 || outp() !== want || in_ready !== 1'b0 ||
                mul_sel !== 2'd0 || out_err !== 1'b0) bad = 1;
            if (i < 5) tick();
        end
        if (bad) begin
            errors++;
            $display("FAIL backpressure_hold vld=%b p=%h rdy=%b want 1 %h 0",
                     out_valid, outp(), in_ready, want);
        end
        checks++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2, cyc;
        trip_t r1, r2;
        out_ready = 1'b1;
        drive({3'd2, 3'd4, 3'd3}, {3'd1, 3'd3, 3'd5}, {3'd3, 3'd5, 3'd7});
        in_valid = 1'b1;
        acc1 = -1;
        acc2 = -1;
        r1 = '0;
        r2 = '0;
        for (cyc = 0; cyc < 14; cyc++) begin
            if (in_ready && in_valid) begin
                if (acc1 < 0) acc1 = cyc;
                else if (acc2 < 0) acc2 = cyc;
            end
            tick();
            if (acc1 >= 0 && acc2 < 0)
                drive({3'd2, 3'd4, 3'd6}, {3'd2, 3'd4, 3'd6}, {3'd3, 3'd5, 3'd7});
            if (acc2 >= 0) in_valid = 1'b0;
            if (out_valid && acc2 < 0) r1 = outp();
            if (out_valid && acc2 >= 0) r2 = outp();
        end
        in_valid = 1'b0;
        if (acc2 - acc1 !== 5) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 5", acc2 - acc1);
        end
        checks++;
        if (r1 !== {3'd2, 3'd2, 3'd1} || r2 !== {3'd1, 3'd1, 3'd1}) begin
            errors++;
            $display("FAIL b2b_results got %h %h want %h %h",
                     r1, r2, {3'd2, 3'd2, 3'd1}, {3'd1, 3'd1, 3'd1});
        end
        checks++;
    endtask

    task automatic test_error_flag();
        trip_t p;
        logic err;
        int lat;
        run_op({3'd4, 3'd0, 3'd3}, {3'd1, 3'd0, 3'd2}, {3'd3, 3'd1, 3'd7},
               2, 0, p, err, lat);
        if (lat !== 4 || err !== 1'b1 || p !== {3'd1, 3'd0, 3'd6}) begin
            errors++;
            $display("FAIL error_flag lat=%0d err=%b p=%h want 4 1 %h",
                     lat, err, p, {3'd1, 3'd0, 3'd6});
        end
        checks++;
    endtask

    task automatic test_input_hold();
        trip_t a, b, m, p;
        logic err;
        int lat;
        for (int n = 0; n < 4; n++) begin
            a = rnd_trip(0);
            b = rnd_trip(0);
            m = rnd_trip(1);
            run_op(a, b, m, 0, 1, p, err, lat);
            if (lat !== 4 || p !== ref_prod(a, b, m) || err !== ref_err(a, b, m)) begin
                errors++;
                $display("FAIL input_hold lat=%0d p=%h err=%b want 4 %h %b",
                         lat, p, err, ref_prod(a, b, m), ref_err(a, b, m));
            end
            checks++;
        end
    endtask

    task automatic test_random();
        trip_t a, b, m, p;
        logic err;
        int lat;
        for (int n = 0; n < 40; n++) begin
            a = rnd_trip(0);
            b = rnd_trip(0);
            m = rnd_trip(1);
            if (n % 2 == 0)
                for (int i = 0; i < 3; i++) begin
                    if (m[i] < 2) m[i] = RW'(2);
                    a[i] = RW'(int'(a[i]) % int'(m[i]));
                    b[i] = RW'(int'(b[i]) % int'(m[i]));
                end
            run_op(a, b, m, $urandom_range(0, 3), $urandom_range(0, 1),
                   p, err, lat);
            if (lat !== 4 || p !== ref_prod(a, b, m) || err !== ref_err(a, b, m)) begin
                errors++;
                $display("FAIL random_%0d lat=%0d p=%h err=%b want 4 %h %b",
                         n, lat, p, err, ref_prod(a, b, m), ref_err(a, b, m));
            end
            checks++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        drive('0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        tick();
        test_error_flag();
        test_input_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
